// File: rtl/sloc_capture_buffer.sv
// Multi-channel pre/post-trigger sample capture: NCH ring buffers of DEPTH samples,
// frozen around a level or forced trigger and read back by window index.
// Latency: rd_data/rd_valid one cycle after rd_req. No backpressure: every sample strobe is
// accepted in ARMED/POST at full rate, and strobes in IDLE/FROZEN are dropped.
// Ports: clk_clk/reset (sync, active-high); arm, sample_valid, sample_data[NCH*W], threshold,
//        trig_ch_en, force_trig in; rd_req/rd_ch/rd_idx in, rd_valid/rd_data out;
//        state, trig_ch, done status out.
module sloc_capture_buffer #(
  parameter int W     = 11,
  parameter int NCH   = 4,
  parameter int DEPTH = 64,
  parameter int PRE   = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_clk,
  input  logic             reset,
  input  logic             arm,
  input  logic             sample_valid,
  input  logic [NCH*W-1:0] sample_data,
  input  logic [W-2:0]     threshold,
  input  logic [NCH-1:0]   trig_ch_en,
  input  logic             force_trig,
  input  logic             rd_req,
  input  logic [2:0]       rd_ch,
  input  logic [AW-1:0]    rd_idx,
  output logic             rd_valid,
  output logic [W-1:0]     rd_data,
  output logic [1:0]       state,
  output logic [2:0]       trig_ch,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ARMED  = 2'b01,
    S_POST   = 2'b10,
    S_FROZEN = 2'b11
  } st_t;

  localparam logic [AW-1:0] PRE_C    = AW'(PRE);
  localparam logic [AW-1:0] POST_LEN = AW'(DEPTH - PRE - 1);

  st_t            st;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  fill;
  logic [AW-1:0]  post_cnt;
  logic [AW-1:0]  trig_ptr;
  logic           force_pending;

  logic [W-1:0]   mem [NCH][DEPTH];

  logic [NCH-1:0] hit;
  logic [2:0]     lo_ch;
  logic           accept;
  logic [AW-1:0]  rd_addr;
  logic [W-1:0]   rd_sel;

  assign state = st;

  // |x| on W-1 bits; the most-negative code saturates to the largest positive magnitude.
  function automatic logic [W-2:0] mag(input logic [W-1:0] x);
    logic [W-1:0] neg;
    neg = (~x) + 1'b1;
    if (x == {1'b1, {(W-1){1'b0}}})
      mag = '1;
    else if (x[W-1])
      mag = neg[W-2:0];
    else
      mag = x[W-2:0];
  endfunction

  always_comb begin
    hit = '0;
    for (int c = 0; c < NCH; c++) begin
      hit[c] = trig_ch_en[c] && (threshold != '0) &&
               (mag(sample_data[c*W +: W]) >= threshold);
    end
  end

  // Lowest-numbered hitting channel wins; 7 is the "forced" code when nothing hit.
  always_comb begin
    lo_ch = 3'd7;
    for (int c = NCH-1; c >= 0; c--) begin
      if (hit[c]) lo_ch = 3'(c);
    end
  end

  // A concurrent arm restarts the capture, so that strobe is not taken into the buffer.
  assign accept = sample_valid && !arm && ((st == S_ARMED) || (st == S_POST));

  // Window starts PRE samples before the trigger sample and wraps naturally at DEPTH.
  assign rd_addr = trig_ptr - PRE_C + rd_idx;

  always_comb begin
    rd_sel = '0;
    for (int c = 0; c < NCH; c++) begin
      if (rd_ch == 3'(c)) rd_sel = mem[c][rd_addr];
    end
  end

  // Sample storage has no reset; contents are only meaningful inside a frozen window.
  always_ff @(posedge clk_clk) begin
    if (!reset && accept) begin
      for (int c = 0; c < NCH; c++) begin
        mem[c][wr_ptr] <= sample_data[c*W +: W];
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset) begin
      st            <= S_IDLE;
      wr_ptr        <= '0;
      fill          <= '0;
      post_cnt      <= '0;
      trig_ptr      <= '0;
      force_pending <= 1'b0;
      rd_valid      <= 1'b0;
      rd_data       <= '0;
      trig_ch       <= '0;
      done          <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (accept) wr_ptr <= wr_ptr + 1'b1;

      unique case (st)
        S_IDLE: begin
          if (arm) begin
            st            <= S_ARMED;
            fill          <= '0;
            force_pending <= 1'b0;
          end
        end

        S_ARMED: begin
          if (arm) begin
            fill          <= '0;
            force_pending <= 1'b0;
          end else begin
            if (force_trig) force_pending <= 1'b1;
            if (sample_valid) begin
              // Triggers are only honoured once the pre-trigger history is full.
              if ((fill == PRE_C) && ((|hit) || force_pending || force_trig)) begin
                trig_ptr      <= wr_ptr;
                trig_ch       <= (|hit) ? lo_ch : 3'd7;
                force_pending <= 1'b0;
                if (POST_LEN == '0) begin
                  st   <= S_FROZEN;
                  done <= 1'b1;
                end else begin
                  st       <= S_POST;
                  post_cnt <= POST_LEN;
                end
              end else if (fill != PRE_C) begin
                fill <= fill + 1'b1;
              end
            end
          end
        end

        S_POST: begin
          if (arm) begin
            st            <= S_ARMED;
            fill          <= '0;
            force_pending <= 1'b0;
          end else if (sample_valid) begin
            post_cnt <= post_cnt - 1'b1;
            if (post_cnt == AW'(1)) begin
              st   <= S_FROZEN;
              done <= 1'b1;
            end
          end
        end

        S_FROZEN: begin
          // Re-arming has priority over a read in the same cycle.
          if (arm) begin
            st            <= S_ARMED;
            done          <= 1'b0;
            fill          <= '0;
            force_pending <= 1'b0;
          end else if (rd_req) begin
            rd_valid <= 1'b1;
            rd_data  <= rd_sel;
          end
        end

        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sloc_capture_buffer.sv
// Directed bench for sloc_capture_buffer: level/forced triggers, pre-fill guard,
// wrap-around window readback, magnitude saturation, reset and rearm/read collision.
// Inputs change on the falling edge; outputs are sampled on the falling edge after the DUT edge.
module tb_sloc_capture_buffer;
  localparam int W     = 11;
  localparam int NCH   = 4;
  localparam int DEPTH = 64;
  localparam int PRE   = 16;
  localparam int AW    = 6;

  logic             clk_clk = 1'b0;
  logic             reset;
  logic             arm;
  logic             sample_valid;
  logic [NCH*W-1:0] sample_data;
  logic [W-2:0]     threshold;
  logic [NCH-1:0]   trig_ch_en;
  logic             force_trig;
  logic             rd_req;
  logic [2:0]       rd_ch;
  logic [AW-1:0]    rd_idx;
  logic             rd_valid;
  logic [W-1:0]     rd_data;
  logic [1:0]       state;
  logic [2:0]       trig_ch;
  logic             done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_clk = ~clk_clk;

  sloc_capture_buffer #(.W(W), .NCH(NCH), .DEPTH(DEPTH), .PRE(PRE)) dut (
    .clk_clk      (clk_clk),
    .reset        (reset),
    .arm          (arm),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .threshold    (threshold),
    .trig_ch_en   (trig_ch_en),
    .force_trig   (force_trig),
    .rd_req       (rd_req),
    .rd_ch        (rd_ch),
    .rd_idx       (rd_idx),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .state        (state),
    .trig_ch      (trig_ch),
    .done         (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_clk);
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic send4(input int d0, input int d1, input int d2, input int d3);
    sample_data  = {W'(d3), W'(d2), W'(d1), W'(d0)};
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic read(input int ch, input int idx, output logic v, output logic [W-1:0] d);
    rd_req = 1'b1;
    rd_ch  = 3'(ch);
    rd_idx = AW'(idx);
    tick();
    rd_req = 1'b0;
    v = rd_valid;
    d = rd_data;
  endtask

  task automatic rchk(input string tag, input int ch, input int idx, input int exp);
    logic         v;
    logic [W-1:0] d;
    read(ch, idx, v, d);
    check({tag, "_vld"}, 32'(v), 32'd1);
    check(tag, 32'(d), 32'(exp));
  endtask

  initial begin
    logic         v;
    logic [W-1:0] d;

    reset = 1'b1; arm = 1'b0; sample_valid = 1'b0; sample_data = '0;
    threshold = '0; trig_ch_en = '0; force_trig = 1'b0;
    rd_req = 1'b0; rd_ch = '0; rd_idx = '0;
    repeat (3) tick();
    check("rst_state",   32'(state),    32'd0);
    check("rst_done",    32'(done),     32'd0);
    check("rst_rdvalid", 32'(rd_valid), 32'd0);
    check("rst_rddata",  32'(rd_data),  32'd0);
    check("rst_trigch",  32'(trig_ch),  32'd0);
    reset = 1'b0;
    tick();

    // Level trigger on a ramp on channel 0.
    threshold  = 10'd40;
    trig_ch_en = 4'b0001;
    pulse_arm();
    check("t2_armed", 32'(state), 32'd1);
    for (int n = 0; n < 100; n++) begin
      send4(n, 0, 0, 0);
      if (n == 39) check("t2_before_trig", 32'(state), 32'd1);
      if (n == 40) check("t2_post",        32'(state), 32'd2);
      if (n == 86) check("t2_still_post",  32'(state), 32'd2);
      if (n == 87) begin
        check("t2_frozen", 32'(state), 32'd3);
        check("t2_done",   32'(done),  32'd1);
      end
    end
    check("t2_trigch", 32'(trig_ch), 32'd0);
    rchk("t2_idx0",  0, 0,  24);
    rchk("t2_idx16", 0, 16, 40);
    rchk("t2_idx63", 0, 63, 87);
    rchk("t2_bad_ch", 5, 16, 0);

    // Pre-fill guard: channel 2 over threshold from the very first sample.
    threshold  = 10'd5;
    trig_ch_en = 4'b0100;
    pulse_arm();
    check("t3_armed", 32'(state), 32'd1);
    check("t3_done",  32'(done),  32'd0);
    for (int k = 1; k <= 17; k++) begin
      send4(k, 0, 1023, 0);
      if (k == 16) check("t3_guard", 32'(state), 32'd1);
      if (k == 17) begin
        check("t3_trig",   32'(state),   32'd2);
        check("t3_trigch", 32'(trig_ch), 32'd2);
      end
    end
    for (int k = 18; k <= 64; k++) send4(k, 0, 1023, 0);
    check("t3_frozen", 32'(state), 32'd3);
    rchk("t3_trig_sample", 0, 16, 17);
    rchk("t3_oldest",      0, 0,  1);
    rchk("t3_ch2",         2, 5,  1023);

    // Reset mid-POST, with arm held to show reset overrides it.
    pulse_arm();
    for (int k = 1; k <= 20; k++) send4(k, 0, 1023, 0);
    check("t1_in_post", 32'(state), 32'd2);
    reset = 1'b1;
    arm   = 1'b1;
    repeat (3) tick();
    arm   = 1'b0;
    reset = 1'b0;
    check("t1_state",   32'(state),    32'd0);
    check("t1_done",    32'(done),     32'd0);
    check("t1_rdvalid", 32'(rd_valid), 32'd0);
    check("t1_trigch",  32'(trig_ch),  32'd0);
    send4(1, 1, 1, 1);
    check("t1_idle_stays", 32'(state), 32'd0);

    // Forced trigger after a long run, window straddles the write-pointer wrap.
    threshold  = '0;
    trig_ch_en = 4'b1111;
    pulse_arm();
    for (int s = 0; s < 200; s++) send4(s, s, s, s);
    check("t4_no_level", 32'(state), 32'd1);
    force_trig = 1'b1;
    tick();
    force_trig = 1'b0;
    check("t4_pending", 32'(state), 32'd1);
    for (int s = 200; s <= 247; s++) begin
      send4(s, s, s, s);
      if (s == 200) check("t4_post", 32'(state), 32'd2);
    end
    check("t4_frozen", 32'(state),   32'd3);
    check("t4_trigch", 32'(trig_ch), 32'd7);
    for (int i = 0; i < DEPTH; i++) rchk($sformatf("t4_win%0d", i), 3, i, 184 + i);

    // Saturated magnitude and channel priority at the top threshold.
    threshold  = 10'd1023;
    trig_ch_en = 4'b1111;
    pulse_arm();
    repeat (16) send4(0, 0, 0, 0);
    send4(0, 0, 0, 1022);
    check("t5_below", 32'(state), 32'd1);
    send4(0, -1024, 0, 1023);
    check("t5_trig",   32'(state),   32'd2);
    check("t5_trigch", 32'(trig_ch), 32'd1);

    // Rearm colliding with a read in FROZEN.
    repeat (47) send4(0, 0, 0, 0);
    check("t6_frozen", 32'(state), 32'd3);
    check("t6_done",   32'(done),  32'd1);
    rchk("t6_sat_read", 1, 16, 1024);
    arm    = 1'b1;
    rd_req = 1'b1;
    rd_ch  = 3'd0;
    rd_idx = '0;
    tick();
    arm    = 1'b0;
    rd_req = 1'b0;
    check("t6_state",   32'(state),    32'd1);
    check("t6_rdvalid", 32'(rd_valid), 32'd0);
    check("t6_done",    32'(done),     32'd0);
    check("t6_hold",    32'(rd_data),  32'd1024);
    read(0, 0, v, d);
    check("t6_read_armed", 32'(v), 32'd0);
    check("t6_data_held",  32'(d), 32'd1024);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
